gshare_bp: RTL and testbench

Parametrised gshare conditional-branch predictor for the CVA6 frontend, the successor to the fixed 2-bit global predictor. It indexes a table of CtrBits-wide saturating counters with PC bits XOR a speculative global history register (GHR). The GHR is shifted at prediction time and repaired from an FTQ-carried snapshot on mispredict. Table initialisation and flush use a row-sweep FSM rather than a single-cycle clear, so the storage maps onto flop arrays or LUTRAM.

---
 rtl/gbp_pkg.sv | 37 +++
 rtl/gshare_bp_sat_counter_upd.sv | 21 ++
 rtl/gshare_bp.sv | 129 ++++++++++++
 tb/tb_gshare_bp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gbp_pkg.sv
// Shared constants, types and derived-size helpers for the gshare branch predictor.
package gbp_pkg;

    typedef enum logic {SWEEP, RUN} gshare_state_e;

    localparam int unsigned PKG_VLEN = 64;

    typedef struct packed {
        logic                valid;
        logic [PKG_VLEN-1:0] pc;
        logic                taken;
        logic                mispredict;
    } gbp_update_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } gbp_prediction_t;

    function automatic int unsigned gbp_offset(input bit rvc);
        return rvc ? 1 : 2;
    endfunction

    function automatic int unsigned gbp_row_bits(input int unsigned nr_entries,
                                                 input int unsigned instr_per_fetch);
        return $clog2(nr_entries / instr_per_fetch);
    endfunction

    function automatic int unsigned gbp_slot_bits(input int unsigned instr_per_fetch);
        return $clog2(instr_per_fetch);
    endfunction

    function automatic int unsigned gbp_weak(input int unsigned ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

endpackage

// File: rtl/gshare_bp_sat_counter_upd.sv
// Combinational saturating up/down step for a W-bit prediction counter.
module sat_counter_upd
    import gbp_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] ctr_i,
    input  logic         inc_i,
    output logic [W-1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != '1) ctr_o = ctr_i + W'(1);
        end else begin
            if (ctr_i != '0) ctr_o = ctr_i - W'(1);
        end
    end

endmodule

// File: rtl/gshare_bp.sv
// gshare predictor: counter table indexed by PC row bits XOR a speculative global history,
// initialised and flushed by a one-row-per-cycle sweep so it maps onto plain RAM-like storage.
module gshare_bp
    import gbp_pkg::*;
#(
    parameter bit          RVC             = 1'b1,
    parameter int unsigned VLEN            = 64,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter bit          DebugEn         = 1'b1,
    parameter type         bht_update_t     = gbp_pkg::gbp_update_t,
    parameter type         bht_prediction_t = gbp_pkg::gbp_prediction_t,
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned CtrBits         = 2,
    parameter int unsigned HistBits        = gbp_row_bits(NR_ENTRIES, INSTR_PER_FETCH)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    flush_bp_i,
    input  logic                                    debug_mode_i,
    input  logic [VLEN-1:0]                         vpc_i,
    input  logic                                    spec_valid_i,
    input  logic                                    spec_taken_i,
    input  bht_update_t                             bht_update_i,
    input  logic [HistBits-1:0]                     update_ghr_i,
    output bht_prediction_t [INSTR_PER_FETCH-1:0]   bht_prediction_o,
    output logic [HistBits-1:0]                     ghr_o,
    output logic                                    ready_o
);

    localparam int unsigned OFFSET    = gbp_offset(RVC);
    localparam int unsigned ROW_BITS  = gbp_row_bits(NR_ENTRIES, INSTR_PER_FETCH);
    localparam int unsigned SLOT_BITS = gbp_slot_bits(INSTR_PER_FETCH);
    localparam int unsigned NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
    localparam logic [CtrBits-1:0] WEAK_CTR = CtrBits'(gbp_weak(CtrBits));

    typedef struct packed {
        logic               valid;
        logic [CtrBits-1:0] ctr;
    } entry_t;

    gshare_state_e       state_q;
    logic [ROW_BITS-1:0] row_q;
    logic [HistBits-1:0] ghr_q, ghr_d;
    entry_t              tbl_q [NR_ROWS][INSTR_PER_FETCH];

    logic                 run, dbg_block, upd_en, spec_en;
    logic [ROW_BITS-1:0]  rd_row, upd_row;
    logic [SLOT_BITS-1:0] upd_slot;
    logic [CtrBits-1:0]   upd_ctr;
    logic                 unused_bits;

    assign run       = (state_q == RUN);
    assign dbg_block = DebugEn && debug_mode_i;
    assign upd_en    = run && bht_update_i.valid && !dbg_block && !flush_bp_i;
    assign spec_en   = run && spec_valid_i && !dbg_block && !flush_bp_i;

    assign rd_row   = vpc_i[ROW_BITS+SLOT_BITS+OFFSET-1 -: ROW_BITS] ^ ROW_BITS'(ghr_q);
    assign upd_row  = bht_update_i.pc[ROW_BITS+SLOT_BITS+OFFSET-1 -: ROW_BITS]
                      ^ ROW_BITS'(update_ghr_i);
    assign upd_slot = bht_update_i.pc[SLOT_BITS+OFFSET-1 -: SLOT_BITS];

    // Only a slice of the PCs feeds the index; the rest is intentionally ignored.
    assign unused_bits = ^{vpc_i, bht_update_i};

    sat_counter_upd #(.W(CtrBits)) u_sat_counter_upd (
        .ctr_i (tbl_q[upd_row][upd_slot].ctr),
        .inc_i (bht_update_i.taken),
        .ctr_o (upd_ctr)
    );

    // Truncating {history, bit} keeps the newest HistBits bits, which also covers HistBits == 1.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_en && bht_update_i.mispredict) begin
            ghr_d = HistBits'({update_ghr_i, bht_update_i.taken});
        end else if (spec_en) begin
            ghr_d = HistBits'({ghr_q, spec_taken_i});
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_bp_i) begin
            state_q <= SWEEP;
            row_q   <= '0;
            ghr_q   <= '0;
        end else begin
            case (state_q)
                SWEEP: begin
                    ghr_q <= '0;
                    if (row_q == ROW_BITS'(NR_ROWS - 1)) begin
                        state_q <= RUN;
                        row_q   <= '0;
                    end else begin
                        row_q <= row_q + ROW_BITS'(1);
                    end
                end
                RUN:     ghr_q   <= ghr_d;
                default: state_q <= SWEEP;
            endcase
        end
    end

    // Table storage carries no reset; the sweep is what makes it defined.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_bp_i) begin
            if (state_q == SWEEP) begin
                for (int s = 0; s < INSTR_PER_FETCH; s++) begin
                    tbl_q[row_q][s] <= '{valid: 1'b0, ctr: WEAK_CTR};
                end
            end else if (upd_en) begin
                tbl_q[upd_row][upd_slot] <= '{valid: 1'b1, ctr: upd_ctr};
            end
        end
    end

    always_comb begin
        bht_prediction_o = '0;
        if (run) begin
            for (int i = 0; i < INSTR_PER_FETCH; i++) begin
                bht_prediction_o[i].valid = tbl_q[rd_row][i].valid;
                bht_prediction_o[i].taken = tbl_q[rd_row][i].ctr[CtrBits-1];
            end
        end
    end

    assign ghr_o   = ghr_q;
    assign ready_o = run;

endmodule

// File: tb/tb_gshare_bp.sv
// Directed bench for gshare_bp (64 entries, 2 slots, 3-bit counters, 4-bit history)
// with a table-level reference model checked every cycle.
module tb_gshare_bp;
    import gbp_pkg::*;

    localparam int NE = 64, IPF = 2, CB = 3, HB = 4, NROWS = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ni, flush, dbg, spec_v, spec_t, ready;
    logic [63:0] vpc;
    gbp_update_t upd;
    logic [HB-1:0] ughr, ghr;
    gbp_prediction_t [IPF-1:0] pred;

    int checks = 0, failures = 0;

    gshare_bp #(
        .RVC(1'b1), .VLEN(64), .INSTR_PER_FETCH(IPF), .DebugEn(1'b1),
        .NR_ENTRIES(NE), .CtrBits(CB), .HistBits(HB)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_bp_i(flush), .debug_mode_i(dbg),
        .vpc_i(vpc), .spec_valid_i(spec_v), .spec_taken_i(spec_t),
        .bht_update_i(upd), .update_ghr_i(ughr),
        .bht_prediction_o(pred), .ghr_o(ghr), .ready_o(ready)
    );

    // Reference model: remaining sweep cycles, history value, counter/valid per entry.
    int sweep_left = 0;
    int mghr = 0;
    int mctr [NROWS][IPF];
    bit mvalid [NROWS][IPF];
    int mr, ms, crow;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_ni || flush) begin
            sweep_left = NROWS;
            mghr = 0;
        end else if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0)
                for (int r = 0; r < NROWS; r++)
                    for (int s = 0; s < IPF; s++) begin
                        mctr[r][s] = 4;
                        mvalid[r][s] = 1'b0;
                    end
        end else if (!dbg) begin
            if (upd.valid) begin
                mr = (int'(upd.pc >> 2) & 31) ^ int'(ughr);
                ms = int'(upd.pc >> 1) & 1;
                mvalid[mr][ms] = 1'b1;
                if (upd.taken) mctr[mr][ms] = (mctr[mr][ms] == 7) ? 7 : mctr[mr][ms] + 1;
                else           mctr[mr][ms] = (mctr[mr][ms] == 0) ? 0 : mctr[mr][ms] - 1;
            end
            if (upd.valid && upd.mispredict) mghr = ((int'(ughr) << 1) | int'(upd.taken)) & 15;
            else if (spec_v)                 mghr = ((mghr << 1) | int'(spec_t)) & 15;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", int'(ready), int'(sweep_left == 0));
            chk("ghr", int'(ghr), mghr);
            crow = (int'(vpc >> 2) & 31) ^ mghr;
            for (int i = 0; i < IPF; i++) begin
                chk("pred_valid", int'(pred[i].valid),
                    int'(sweep_left == 0 && mvalid[crow][i]));
                chk("pred_taken", int'(pred[i].taken),
                    int'(sweep_left == 0 && mctr[crow][i] >= 4));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_upd(input logic [63:0] pc, input logic t, input logic mis,
                            input logic [3:0] snap);
        upd.valid = 1'b1; upd.pc = pc; upd.taken = t; upd.mispredict = mis; ughr = snap;
        tick();
        upd.valid = 1'b0; upd.mispredict = 1'b0;
    endtask

    task automatic spec(input logic t);
        spec_v = 1'b1; spec_t = t;
        tick();
        spec_v = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (ready) begin
                n = k;
                break;
            end
        end
        chk(nm, n, NROWS);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; flush = 1'b0; dbg = 1'b0; spec_v = 1'b0; spec_t = 1'b0;
        vpc = '0; ughr = '0; upd = '0;
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        chk("reset_ready", int'(ready), 0);
        chk("reset_ghr", int'(ghr), 0);
        rst_ni = 1'b1;
        wait_ready("reset_sweep_len");
        chk("init_valid", int'(pred[0].valid), 0);
        chk("init_taken_weak", int'(pred[0].taken), 1);

        // Saturate row 0 slot 0 upward (4 -> 7), then walk back down to 3.
        repeat (6) send_upd(64'd0, 1'b1, 1'b0, 4'd0);
        chk("sat_valid", int'(pred[0].valid), 1);
        chk("sat_taken", int'(pred[0].taken), 1);
        chk("other_slot_valid", int'(pred[1].valid), 0);
        repeat (3) send_upd(64'd0, 1'b0, 1'b0, 4'd0);
        chk("dec_to_4_taken", int'(pred[0].taken), 1);
        send_upd(64'd0, 1'b0, 1'b0, 4'd0);
        chk("dec_to_3_taken", int'(pred[0].taken), 0);

        // Speculative history 1,0,1.
        spec(1'b1); chk("ghr_0001", int'(ghr), 1);
        spec(1'b0); chk("ghr_0010", int'(ghr), 2);
        spec(1'b1); chk("ghr_0101", int'(ghr), 5);
        chk("pc0_row5_valid", int'(pred[0].valid), 0);
        vpc = 64'd20;
        #1;
        chk("pc20_row0_valid", int'(pred[0].valid), 1);
        chk("pc20_row0_taken", int'(pred[0].taken), 0);

        // Mispredict repair wins over a simultaneous speculative shift.
        spec_v = 1'b1; spec_t = 1'b0;
        send_upd(64'd8, 1'b1, 1'b1, 4'b0110);
        spec_v = 1'b0;
        chk("ghr_repair_1101", int'(ghr), 13);
        vpc = 64'd36;
        #1;
        chk("repair_entry_valid", int'(pred[0].valid), 1);
        chk("repair_entry_taken", int'(pred[0].taken), 1);

        // Same-cycle read and update of row 0 slot 0 (counter 3 -> 4).
        vpc = 64'd52;
        upd.valid = 1'b1; upd.pc = 64'd0; upd.taken = 1'b1; upd.mispredict = 1'b0; ughr = 4'd0;
        #2;
        chk("same_cycle_old", int'(pred[0].taken), 0);
        @(posedge clk);
        #1;
        upd.valid = 1'b0;
        chk("same_cycle_new", int'(pred[0].taken), 1);

        // Debug mode drops updates and shifts.
        dbg = 1'b1; spec_v = 1'b1; spec_t = 1'b1;
        send_upd(64'd0, 1'b0, 1'b0, 4'd0);
        send_upd(64'd0, 1'b0, 1'b0, 4'd0);
        spec_v = 1'b0; dbg = 1'b0;
        chk("debug_ghr_held", int'(ghr), 13);
        chk("debug_ctr_held", int'(pred[0].taken), 1);

        // Flush, drop an update mid-sweep, restart the sweep at row 10.
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_ghr", int'(ghr), 0);
        chk("flush_ready", int'(ready), 0);
        repeat (2) tick();
        send_upd(64'd0, 1'b1, 1'b0, 4'd0);
        repeat (7) tick();
        chk("mid_sweep_ready", int'(ready), 0);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_ready("flush_restart_len");
        vpc = 64'd0;
        #1;
        chk("lost_upd_valid", int'(pred[0].valid), 0);
        chk("lost_upd_weak", int'(pred[0].taken), 1);
        chk("lost_upd_slot1", int'(pred[1].valid), 0);
        repeat (3) tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
